// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: green/yellow/all-red phase FSM with phase second counter and EW traffic tallies
module traffic_phase_sequencer #(
  parameter int ALLRED_SEC = 2,
  parameter int GREEN_MAX  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       veh_ew,
  input  logic       green_expire,
  input  logic       yellow_expire,
  input  logic       red_release,
  output logic [5:0] phase_cnt,
  output logic [6:0] no_traffic_sec_ew,
  output logic [4:0] traffic_sec_ew,
  output logic [2:0] ew_light,
  output logic [2:0] ns_light,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    START_RED = 3'd0, EW_GREEN = 3'd1, EW_YELLOW = 3'd2, ALLRED_A = 3'd3,
    NS_GREEN = 3'd4, NS_YELLOW = 3'd5, ALLRED_B = 3'd6
  } phase_e;
  localparam logic [5:0] A_LAST = 6'(ALLRED_SEC - 1);
  localparam logic [5:0] G_LAST = 6'(GREEN_MAX - 1);
  localparam logic [5:0] Y_LAST = 6'd7;
  phase_e     phase_q, phase_d;
  logic [5:0] phase_cnt_q, phase_cnt_d;
  logic [6:0] no_traffic_q, no_traffic_d;
  logic [4:0] traffic_q, traffic_d;
  logic [2:0] ew_light_q, ew_light_d, ns_light_q, ns_light_d;
  logic       go, enter_ew, ew_red;
  always_comb begin
    case (phase_q)
      START_RED, ALLRED_A, ALLRED_B: go = phase_cnt_q == A_LAST;
      EW_GREEN:                      go = green_expire || phase_cnt_q == G_LAST;
      NS_GREEN:                      go = red_release || phase_cnt_q == G_LAST;
      EW_YELLOW, NS_YELLOW:          go = yellow_expire || phase_cnt_q == Y_LAST;
      default:                       go = 1'b0;
    endcase
    enter_ew = go && (phase_q == START_RED || phase_q == ALLRED_B);
    ew_red = ew_light_q == 3'b100;
    phase_d = phase_q;
    phase_cnt_d = phase_cnt_q;
    no_traffic_d = no_traffic_q;
    traffic_d = traffic_q;
    // encoding 7 is unreachable in normal operation; recover without waiting for a tick
    if (phase_q == 3'd7) begin
      phase_d = START_RED;
      phase_cnt_d = '0;
    end else if (tick_1s) begin
      phase_d = !go ? phase_q : phase_q == ALLRED_B ? EW_GREEN : phase_e'(phase_q + 3'd1);
      phase_cnt_d = go ? '0 : &phase_cnt_q ? phase_cnt_q : phase_cnt_q + 6'd1;
      no_traffic_d = enter_ew ? '0 : phase_q != EW_GREEN ? no_traffic_q :
                     veh_ew ? '0 : &no_traffic_q ? no_traffic_q : no_traffic_q + 7'd1;
      traffic_d = enter_ew ? '0 : (ew_red && veh_ew && !(&traffic_q)) ? traffic_q + 5'd1 : traffic_q;
    end
    ew_light_d = phase_d == EW_GREEN ? 3'b001 : phase_d == EW_YELLOW ? 3'b010 : 3'b100;
    ns_light_d = phase_d == NS_GREEN ? 3'b001 : phase_d == NS_YELLOW ? 3'b010 : 3'b100;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= START_RED;
      phase_cnt_q <= '0;
      no_traffic_q <= '0;
      traffic_q <= '0;
      ew_light_q <= 3'b100;
      ns_light_q <= 3'b100;
    end else begin
      phase_q <= phase_d;
      phase_cnt_q <= phase_cnt_d;
      no_traffic_q <= no_traffic_d;
      traffic_q <= traffic_d;
      ew_light_q <= ew_light_d;
      ns_light_q <= ns_light_d;
    end
  end
  assign phase = phase_q;
  assign phase_cnt = phase_cnt_q;
  assign no_traffic_sec_ew = no_traffic_q;
  assign traffic_sec_ew = traffic_q;
  assign ew_light = ew_light_q;
  assign ns_light = ns_light_q;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: directed walk through the light cycle plus random ticks/decisions against a rule-table model
module tb_traffic_phase_sequencer;
  localparam int AR = 2;
  localparam int GM = 60;
  logic clk = 0, rst_n = 0, tick_1s = 0, veh_ew = 0;
  logic green_expire = 0, yellow_expire = 0, red_release = 0;
  logic [5:0] phase_cnt;
  logic [6:0] no_traffic_sec_ew;
  logic [4:0] traffic_sec_ew;
  logic [2:0] ew_light, ns_light, phase;
  int checks = 0, errors = 0;
  int m_st = 0, m_cnt = 0, m_nt = 0, m_tr = 0;
  int nxt[7]   = '{1, 2, 3, 4, 5, 6, 1};
  int ew_of[7] = '{4, 1, 2, 4, 4, 4, 4};
  int ns_of[7] = '{4, 4, 4, 4, 1, 2, 4};
  always #5 clk = ~clk;
  traffic_phase_sequencer #(.ALLRED_SEC(AR), .GREEN_MAX(GM)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .veh_ew(veh_ew),
    .green_expire(green_expire), .yellow_expire(yellow_expire), .red_release(red_release),
    .phase_cnt(phase_cnt), .no_traffic_sec_ew(no_traffic_sec_ew), .traffic_sec_ew(traffic_sec_ew),
    .ew_light(ew_light), .ns_light(ns_light), .phase(phase)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic compare_all();
    check("phase", int'(phase), m_st);
    check("phase_cnt", int'(phase_cnt), m_cnt);
    check("no_traffic", int'(no_traffic_sec_ew), m_nt);
    check("traffic", int'(traffic_sec_ew), m_tr);
    check("ew_light", int'(ew_light), ew_of[m_st]);
    check("ns_light", int'(ns_light), ns_of[m_st]);
    check("dual_green", int'(ew_light == 3'b001 && ns_light == 3'b001), 0);
  endtask
  task automatic model_tick(input bit ge, input bit ye, input bit rr, input bit v);
    bit ex, enter;
    if (m_st == 0 || m_st == 3 || m_st == 6) ex = m_cnt == AR - 1;
    else if (m_st == 1) ex = ge || m_cnt == GM - 1;
    else if (m_st == 4) ex = rr || m_cnt == GM - 1;
    else ex = ye || m_cnt == 7;
    enter = ex && nxt[m_st] == 1;
    if (enter) m_nt = 0;
    else if (m_st == 1) m_nt = v ? 0 : (m_nt < 127 ? m_nt + 1 : 127);
    if (enter) m_tr = 0;
    else if (ew_of[m_st] == 4 && v) m_tr = m_tr < 31 ? m_tr + 1 : 31;
    m_cnt = ex ? 0 : (m_cnt < 63 ? m_cnt + 1 : 63);
    if (ex) m_st = nxt[m_st];
  endtask
  task automatic step(input bit t, input bit ge, input bit ye, input bit rr, input bit v);
    tick_1s = t; green_expire = ge; yellow_expire = ye; red_release = rr; veh_ew = v;
    @(posedge clk);
    if (t) model_tick(ge, ye, rr, v);
    #1 compare_all();
  endtask
  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_nt = 0; m_tr = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    tick_1s = 0; green_expire = 0; yellow_expire = 0; red_release = 0; veh_ew = 0;
    rst_n = 0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic start_up();
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    check("start_ew_green", int'(phase), 1);
    check("start_ew_light", int'(ew_light), 1);
    check("start_cnt", int'(phase_cnt), 0);
  endtask
  initial begin
    bit v = 0;
    int guard;
    do_reset();
    start_up();
    repeat (30) step(1, 0, 0, 0, 0);
    check("no_traffic_30", int'(no_traffic_sec_ew), 30);
    step(1, 1, 0, 0, 0);
    check("ew_yellow", int'(phase), 2);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    check("allred_a", int'(phase), 3);
    repeat (2) step(1, 0, 0, 0, 0);
    check("ns_green", int'(ns_light), 1);
    repeat (40) step(1, 0, 0, 0, 1);
    check("traffic_sat", int'(traffic_sec_ew), 31);
    step(1, 0, 0, 1, 1);
    check("ns_yellow", int'(phase), 5);
    step(1, 0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0);
    check("back_ew_green", int'(phase), 1);
    check("traffic_cleared", int'(traffic_sec_ew), 0);
    repeat (59) step(1, 0, 0, 0, 0);
    check("green_cnt_59", int'(phase_cnt), 59);
    step(1, 0, 0, 0, 0);
    check("green_ceiling", int'(phase), 2);
    repeat (8) step(1, 0, 0, 0, 0);
    check("yellow_force", int'(phase), 3);
    repeat (4000) begin
      if ($urandom % 8 == 0) v = ~v;
      step($urandom % 3 == 0, $urandom % 40 == 0, $urandom % 6 == 0, $urandom % 30 == 0, v);
    end
    guard = 0;
    while (m_st != 4 && guard < 2000) begin
      step(1, $urandom % 10 == 0, $urandom % 4 == 0, 0, $urandom % 2 == 1);
      guard++;
    end
    check("reach_ns_green", m_st, 4);
    #2 rst_n = 0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst_n = 1;
    start_up();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
